// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: the CPU (MA stage) has fixed priority over an
// external/debug requester, a starvation counter gives the external side a
// slot after StarveLimit lost cycles, and read data returns one cycle after
// the grant, steered to the requester that issued the read.
module dm_port_arbiter #(
  parameter int unsigned AddrBits    = 10,
  parameter int unsigned StarveLimit = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  // CPU (MA stage) side
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [AddrBits-1:0] cpu_addr,
  input  logic [31:0]         cpu_wdata,
  output logic                cpu_stall,
  output logic                cpu_rvalid,
  output logic [31:0]         cpu_rdata,
  // External / debug side
  input  logic                ext_req,
  input  logic                ext_we,
  input  logic [AddrBits-1:0] ext_addr,
  input  logic [31:0]         ext_wdata,
  output logic                ext_gnt,
  output logic                ext_rvalid,
  output logic [31:0]         ext_rdata,
  // Memory port
  output logic                mem_en,
  output logic                mem_we,
  output logic [AddrBits-1:0] mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata
);

  localparam logic [3:0] StarveMax = 4'(StarveLimit);

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnCpu  = 2'd1,
    OwnExt  = 2'd2
  } rd_owner_e;

  rd_owner_e  rd_owner_q, rd_owner_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       gnt_cpu, gnt_ext;

  // Grant decision and memory-port mux; nothing is granted while disabled.
  always_comb begin
    gnt_ext   = en && ext_req && (!cpu_req || (starve_cnt_q == StarveMax));
    gnt_cpu   = en && cpu_req && !gnt_ext;
    cpu_stall = cpu_req && !gnt_cpu;
    ext_gnt   = gnt_ext;
    mem_en    = gnt_cpu || gnt_ext;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_cpu) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (gnt_ext) begin
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end
  end

  // Starvation counter next state: counts CPU wins while ext waits, saturating.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (en) begin
      if (gnt_ext || !ext_req) begin
        starve_cnt_d = '0;
      end else if (gnt_cpu && (starve_cnt_q != StarveMax)) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end
  end

  // Read-return owner next state and the steered read-data outputs.
  always_comb begin
    rd_owner_d = rd_owner_q;
    if (en) begin
      rd_owner_d = OwnNone;
      if (gnt_cpu && !cpu_we) begin
        rd_owner_d = OwnCpu;
      end else if (gnt_ext && !ext_we) begin
        rd_owner_d = OwnExt;
      end
    end
    cpu_rvalid = (rd_owner_q == OwnCpu);
    ext_rvalid = (rd_owner_q == OwnExt);
    cpu_rdata  = cpu_rvalid ? mem_rdata : 32'h0;
    ext_rdata  = ext_rvalid ? mem_rdata : 32'h0;
  end

  // State registers; reset drops any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_owner_q   <= OwnNone;
      starve_cnt_q <= '0;
    end else begin
      rd_owner_q   <= rd_owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Arbitrates the single data-memory port between two requesters: the pipeline MA stage (CPU) and an external/debug requester (program loader, debug DM access).
- The CPU has fixed priority. A starvation counter guarantees the external side a slot after StarveLimit lost cycles.
- When the CPU loses arbitration, cpu_stall is raised. The pipeline interlock controller uses it to freeze the pipeline.
- Read data comes back one cycle after the grant and is routed to the requester that issued the read.

Parameters:
AddrBits, 10, word-address width of the data memory
StarveLimit, 4, consecutive lost cycles before ext preempts the CPU (legal range 1..15)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  global enable; when 0, the arbiter state freezes
cpu_req  in  1  MA-stage memory access request
cpu_we  in  1  CPU write (1) / read (0)
cpu_addr  in  AddrBits  CPU word address
cpu_wdata  in  32  CPU write data
cpu_stall  out  1  CPU request not granted this cycle
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  32  CPU read data
ext_req  in  1  external request
ext_we  in  1  external write/read
ext_addr  in  AddrBits  external word address
ext_wdata  in  32  external write data
ext_gnt  out  1  external request granted this cycle
ext_rvalid  out  1  external read data valid
ext_rdata  out  32  external read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AddrBits  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, synchronous, valid 1 cycle after the read strobe

Behaviour:
- Reset (async, rst_n=0): starve_cnt=0, rd_owner=NONE, cpu_rvalid=0, ext_rvalid=0. Combinational outputs follow from the reset state and the current inputs.
- Grant decision (combinational, only when en=1):
  - gnt_ext = ext_req && (!cpu_req || starve_cnt == StarveLimit)
  - gnt_cpu = cpu_req && !gnt_ext
  - When en=0: no grant, mem_en=0, ext_gnt=0, cpu_stall=cpu_req.
- cpu_stall = cpu_req && !gnt_cpu. ext_gnt = gnt_ext.
- Memory port:
  - mem_en = gnt_cpu || gnt_ext.
  - mem_we, mem_addr and mem_wdata come from the granted requester.
  - With no grant: mem_we=0, and addr/wdata are 0.
- Starvation counter (4-bit register, updates only when en=1):
  - If ext granted, or ext_req=0: clear to 0.
  - Else if ext_req && gnt_cpu: increment, saturating at StarveLimit.
  - The preemption cycle clears the counter, so the CPU regains priority on the next cycle.
- Read-return FSM (rd_owner register, states NONE/CPU/EXT, updates only when en=1):
  - Next state: CPU if gnt_cpu && !cpu_we; EXT if gnt_ext && !ext_we; otherwise NONE.
  - cpu_rvalid is registered, 1 exactly when rd_owner==CPU. It is 1 one cycle after the granted read.
  - ext_rvalid is the same for rd_owner==EXT.
  - cpu_rdata = mem_rdata when rd_owner==CPU, else 0. ext_rdata follows the same rule.
  - Writes produce no rvalid.
- Latency: a granted read is followed by rvalid+rdata in the next cycle. Back-to-back reads are sustained at 1 per cycle, with independent owners per cycle.
- en=0 with a read in flight: rd_owner and rvalid hold their values, and rdata continues to track mem_rdata. The memory must hold its output while en=0.
- Simultaneous cpu_req and ext_req with counter below limit: CPU wins and ext waits. The ext side must hold req/we/addr/wdata stable until ext_gnt.
- CPU starvation is bounded: ext preempts at most one cycle in every StarveLimit+1 cycles of contention.
- Reset mid-read: the pending rvalid is dropped (never asserted) and the counter returns to 0.

Test Plan:
- Reset, then CPU-only read of addr 0x005 with mem word 0xDEADBEEF -> cycle 0: mem_en=1, mem_addr=0x005, cpu_stall=0; cycle 1: cpu_rvalid=1, cpu_rdata=0xDEADBEEF, ext_rvalid=0.
- Ext-only write (addr 0x3FF, data 0x12345678, cpu_req=0) -> ext_gnt=1 same cycle, mem_we=1, mem_addr=0x3FF, mem_wdata=0x12345678; no rvalid the next cycle.
- cpu_req and ext_req held continuously, StarveLimit=4 -> CPU granted cycles 0-3 (cpu_stall=0, ext_gnt=0); cycle 4: ext_gnt=1, cpu_stall=1; cycle 5: CPU granted again, counter=0.
- Alternating owners: CPU read at cycle 0, ext read at cycle 1 (CPU idle) -> cpu_rvalid only at cycle 1, ext_rvalid only at cycle 2, with the correct data on each.
- en=0 for 3 cycles during contention with counter=2 -> no mem_en, counter holds at 2; after en=1, ext wins after 2 further CPU grants.
- rst_n pulsed low in the cycle after a granted CPU read -> cpu_rvalid=0 immediately (async), starve_cnt=0, and no rvalid after release.
